dequantizer_pipe: RTL and testbench

- Converts a signed 32-bit quantization level into an IEEE-754 single-precision value.
- Multiplies by one of two fixed FP32 scale constants: weight or activation, selected per sample.
- Fully pipelined: one new sample per clock, fixed 5-cycle latency.
- Sits between the integer quantized-data path and the FP32 compute datapath.

---
 rtl/dequantizer_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_dequantizer_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dequantizer_pipe.sv
// dequantizer_pipe: signed 32-bit quantization level -> FP32, multiplied by a per-sample
// weight/activation scale; 5-stage pipeline. Define DEQ_SATURATE_EN to clamp overflow to max finite.
module dequantizer_pipe #(
    parameter logic [31:0] W_SCALE = 32'h3ABFFFE0,
    parameter logic [31:0] A_SCALE = 32'h36200013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] level_int,
    input  logic               is_weight,
    output logic        [31:0] weight_fp_reg,
    output logic               ovfl_reg,
    output logic               unfl_reg,
    output logic               excp_reg
);

    function automatic logic [4:0] lead_one(input logic [31:0] v);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) pos = i[4:0];
        end
        return pos;
    endfunction

    function automatic logic rne_up(input logic lsb, input logic guard,
                                    input logic round, input logic sticky);
        return guard & (round | sticky | lsb);
    endfunction

    function automatic logic [31:0] ovfl_result(input logic sign);
`ifdef DEQ_SATURATE_EN
        return {sign, 31'h7F7FFFFF};
`else
        return {sign, 31'h7F800000};
`endif
    endfunction

    // Stage 1: capture the level and the scale chosen for this sample
    logic signed [31:0] level_p1;
    logic        [31:0] scale_p1;
    logic               vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_p1 <= '0;
            scale_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            level_p1 <= level_int;
            scale_p1 <= is_weight ? W_SCALE : A_SCALE;
            vld_p1   <= 1'b1;
        end
    end

    // Stage 2: integer to FP32 with round-to-nearest-even, scale unpacked alongside
    logic        a_sign_c;
    logic [31:0] a_mag_c;
    logic [31:0] a_norm_c;
    logic [4:0]  a_pos_c;
    logic [24:0] a_sum_c;
    logic [23:0] a_man_c;
    logic [7:0]  a_exp_c;

    always_comb begin
        a_sign_c = level_p1[31];
        // -2^31 negates to itself, which read unsigned is the required 2^31
        a_mag_c  = a_sign_c ? unsigned'(-level_p1) : unsigned'(level_p1);
        a_pos_c  = lead_one(a_mag_c);
        a_norm_c = a_mag_c << (5'd31 - a_pos_c);
        a_sum_c  = {1'b0, a_norm_c[31:8]}
                 + {24'd0, rne_up(a_norm_c[8], a_norm_c[7], a_norm_c[6], |a_norm_c[5:0])};
        a_man_c  = a_sum_c[24] ? 24'h800000 : a_sum_c[23:0];
        a_exp_c  = 8'd127 + {3'd0, a_pos_c} + {7'd0, a_sum_c[24]};
    end

    logic        a_sign_p2, a_zero_p2;
    logic [7:0]  a_exp_p2;
    logic [23:0] a_man_p2;
    logic        b_sign_p2, b_zero_p2, b_spec_p2, b_nan_p2;
    logic [7:0]  b_exp_p2;
    logic [23:0] b_man_p2;
    logic        vld_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sign_p2 <= 1'b0;
            a_zero_p2 <= 1'b0;
            a_exp_p2  <= '0;
            a_man_p2  <= '0;
            b_sign_p2 <= 1'b0;
            b_zero_p2 <= 1'b0;
            b_spec_p2 <= 1'b0;
            b_nan_p2  <= 1'b0;
            b_exp_p2  <= '0;
            b_man_p2  <= '0;
            vld_p2    <= 1'b0;
        end else begin
            a_sign_p2 <= a_sign_c;
            a_zero_p2 <= (level_p1 == 32'sd0);
            a_exp_p2  <= a_exp_c;
            a_man_p2  <= a_man_c;
            b_sign_p2 <= scale_p1[31];
            // denormal scales are treated as zero, so exponent 0 alone marks zero
            b_zero_p2 <= (scale_p1[30:23] == 8'h00);
            b_spec_p2 <= (scale_p1[30:23] == 8'hFF);
            b_nan_p2  <= (scale_p1[30:23] == 8'hFF) && (scale_p1[22:0] != 23'd0);
            b_exp_p2  <= scale_p1[30:23];
            b_man_p2  <= {1'b1, scale_p1[22:0]};
            vld_p2    <= vld_p1;
        end
    end

    // Stage 3: mantissa product, sign and exponent sum
    logic signed [9:0] exp_sum_c;

    always_comb begin
        exp_sum_c = signed'({2'b00, a_exp_p2}) + signed'({2'b00, b_exp_p2}) - 10'sd127;
    end

    logic [47:0]       prod_p3;
    logic signed [9:0] exp_p3;
    logic              sign_p3, zero_p3, excp_p3, nan_p3;
    logic              vld_p3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_p3 <= '0;
            exp_p3  <= '0;
            sign_p3 <= 1'b0;
            zero_p3 <= 1'b0;
            excp_p3 <= 1'b0;
            nan_p3  <= 1'b0;
            vld_p3  <= 1'b0;
        end else begin
            prod_p3 <= {24'd0, a_man_p2} * {24'd0, b_man_p2};
            exp_p3  <= exp_sum_c;
            sign_p3 <= a_sign_p2 ^ b_sign_p2;
            zero_p3 <= (a_zero_p2 | b_zero_p2) & ~b_spec_p2;
            excp_p3 <= b_spec_p2;
            nan_p3  <= b_nan_p2 | (b_spec_p2 & a_zero_p2);
            vld_p3  <= vld_p2;
        end
    end

    // Stage 4: normalize the product into [1,2) and round to nearest even
    logic [22:0]       m_frac_c;
    logic              m_guard_c, m_round_c, m_sticky_c;
    logic [23:0]       m_sum_c;
    logic signed [9:0] m_exp_c;

    always_comb begin
        if (prod_p3[47]) begin
            m_frac_c   = prod_p3[46:24];
            m_guard_c  = prod_p3[23];
            m_round_c  = prod_p3[22];
            m_sticky_c = |prod_p3[21:0];
        end else begin
            m_frac_c   = prod_p3[45:23];
            m_guard_c  = prod_p3[22];
            m_round_c  = prod_p3[21];
            m_sticky_c = |prod_p3[20:0];
        end
        // a carry out of the fraction means the significand rolled over to 2.0
        m_sum_c = {1'b0, m_frac_c}
                + {23'd0, rne_up(m_frac_c[0], m_guard_c, m_round_c, m_sticky_c)};
        m_exp_c = exp_p3 + signed'({9'd0, prod_p3[47]}) + signed'({9'd0, m_sum_c[23]});
    end

    logic [22:0]       frac_p4;
    logic signed [9:0] exp_p4;
    logic              sign_p4, zero_p4, excp_p4, nan_p4;
    logic              vld_p4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frac_p4 <= '0;
            exp_p4  <= '0;
            sign_p4 <= 1'b0;
            zero_p4 <= 1'b0;
            excp_p4 <= 1'b0;
            nan_p4  <= 1'b0;
            vld_p4  <= 1'b0;
        end else begin
            frac_p4 <= m_sum_c[22:0];
            exp_p4  <= m_exp_c;
            sign_p4 <= sign_p3;
            zero_p4 <= zero_p3;
            excp_p4 <= excp_p3;
            nan_p4  <= nan_p3;
            vld_p4  <= vld_p3;
        end
    end

    // Stage 5: special-case resolution, packing and output registers
    logic [31:0] res_c;
    logic        ovfl_c, unfl_c, excp_c;

    always_comb begin
        res_c  = {sign_p4, exp_p4[7:0], frac_p4};
        ovfl_c = 1'b0;
        unfl_c = 1'b0;
        excp_c = 1'b0;
        if (excp_p4) begin
            excp_c = 1'b1;
            res_c  = nan_p4 ? 32'h7FC00000 : {sign_p4, 31'h7F800000};
        end else if (zero_p4) begin
            res_c = {sign_p4, 31'd0};
        end else if (exp_p4 >= 10'sd255) begin
            ovfl_c = 1'b1;
            res_c  = ovfl_result(sign_p4);
        end else if (exp_p4 <= 10'sd0) begin
            unfl_c = 1'b1;
            res_c  = {sign_p4, 31'd0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_fp_reg <= '0;
            ovfl_reg      <= 1'b0;
            unfl_reg      <= 1'b0;
            excp_reg      <= 1'b0;
        end else if (vld_p4) begin
            weight_fp_reg <= res_c;
            ovfl_reg      <= ovfl_c;
            unfl_reg      <= unfl_c;
            excp_reg      <= excp_c;
        end else begin
            weight_fp_reg <= '0;
            ovfl_reg      <= 1'b0;
            unfl_reg      <= 1'b0;
            excp_reg      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dequantizer_pipe.sv
// Scoreboard bench for dequantizer_pipe: three instances (default, overflow-prone and
// special-value scales) checked against an exact-integer FP32 reference model.
module tb_dequantizer_pipe;

    localparam logic [31:0] W0 = 32'h3ABFFFE0;
    localparam logic [31:0] A0 = 32'h36200013;
    localparam logic [31:0] W1 = 32'h7F000000;
    localparam logic [31:0] A1 = 32'h00800000;
    localparam logic [31:0] W2 = 32'h7FC00000;
    localparam logic [31:0] A2 = 32'h7F800000;

    logic clk = 1'b0;
    logic rst;
    logic signed [31:0] level_int;
    logic is_weight;

    logic [31:0] res0, res1, res2;
    logic ov0, un0, ex0, ov1, un1, ex1, ov2, un2, ex2;

    dequantizer_pipe dut0 (
        .clk(clk), .rst(rst), .level_int(level_int), .is_weight(is_weight),
        .weight_fp_reg(res0), .ovfl_reg(ov0), .unfl_reg(un0), .excp_reg(ex0)
    );
    dequantizer_pipe #(.W_SCALE(W1), .A_SCALE(A1)) dut1 (
        .clk(clk), .rst(rst), .level_int(level_int), .is_weight(is_weight),
        .weight_fp_reg(res1), .ovfl_reg(ov1), .unfl_reg(un1), .excp_reg(ex1)
    );
    dequantizer_pipe #(.W_SCALE(W2), .A_SCALE(A2)) dut2 (
        .clk(clk), .rst(rst), .level_int(level_int), .is_weight(is_weight),
        .weight_fp_reg(res2), .ovfl_reg(ov2), .unfl_reg(un2), .excp_reg(ex2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          tag;
        logic [34:0] e0, e1, e2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_n  = 0;
    bit   draining = 1'b0;
    bit   mon_done = 1'b0;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got flags=%b value=%h, expected flags=%b value=%h",
                     name, act[34:32], act[31:0], req[34:32], req[31:0]);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_d0"}, {ex0, ov0, un0, res0}, 35'd0);
        chk({name, "_d1"}, {ex1, ov1, un1, res1}, 35'd0);
        chk({name, "_d2"}, {ex2, ov2, un2, res2}, 35'd0);
    endtask

    // Exact rounding of m * 2^e to a 24-bit significand; value = mant * 2^ex afterwards
    function automatic void round_sig(input longint unsigned m, input int e,
                                      output longint unsigned mant, output int ex);
        int p;
        p = 0;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        if (p <= 23) begin
            mant = m << (23 - p);
            ex   = e - (23 - p);
        end else begin
            int s;
            longint unsigned q, rem, half;
            s    = p - 23;
            q    = m >> s;
            rem  = m - (q << s);
            half = 64'd1 << (s - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                s = s + 1;
            end
            mant = q;
            ex   = e + s;
        end
    endfunction

    // Returns {excp, ovfl, unfl, result}
    function automatic logic [34:0] model(input logic [31:0] lvl, input logic [31:0] sc);
        logic            sgn;
        logic [7:0]      se;
        logic [22:0]     sf;
        longint unsigned mag, ma, mb, mr;
        int              ea, eb, er, be;
        sgn = lvl[31] ^ sc[31];
        se  = sc[30:23];
        sf  = sc[22:0];
        mag = lvl[31] ? ((64'd1 << 32) - {32'd0, lvl}) : {32'd0, lvl};
        if (se == 8'hFF) begin
            if (sf != 23'd0 || mag == 0) return {3'b100, 32'h7FC00000};
            return {3'b100, sgn, 31'h7F800000};
        end
        if (se == 8'h00 || mag == 0) return {3'b000, sgn, 31'd0};
        round_sig(mag, 0, ma, ea);
        mb = {40'd0, 1'b1, sf};
        eb = int'(se) - 150;
        round_sig(ma * mb, ea + eb, mr, er);
        be = er + 150;
        if (be >= 255) begin
`ifdef DEQ_SATURATE_EN
            return {3'b010, sgn, 31'h7F7FFFFF};
`else
            return {3'b010, sgn, 31'h7F800000};
`endif
        end
        if (be <= 0) return {3'b001, sgn, 31'd0};
        return {3'b000, sgn, be[7:0], mr[22:0]};
    endfunction

    task automatic send(input logic [31:0] lvl, input logic w);
        exp_t e;
        level_int = lvl;
        is_weight = w;
        e.due = cyc + 5;
        e.tag = tag_n++;
        e.e0  = model(lvl, w ? W0 : A0);
        e.e1  = model(lvl, w ? W1 : A1);
        e.e2  = model(lvl, w ? W2 : A2);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic send_random(input int n);
        logic [31:0] l;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: l = $urandom;
                1: begin
                    l = $urandom_range(0, 70000);
                    if ($urandom_range(0, 1) == 1) l = -l;
                end
                2: l = {$urandom_range(0, 1) == 1 ? 8'h80 : 8'h7F, 24'($urandom)};
                default: l = (32'd1 << $urandom_range(0, 30)) + 32'($urandom_range(0, 3)) - 32'd1;
            endcase
            send(l, 1'($urandom_range(0, 1)));
        end
    endtask

    // Monitor: every cycle outside reset the DUT presents a result or an empty pipe
    initial begin
        exp_t e;
        while (!mon_done) begin
            @(posedge clk);
            #1;
            if (rst) begin
                check_zero("rst_hold");
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk($sformatf("s%0d_d0", e.tag), {ex0, ov0, un0, res0}, e.e0);
                chk($sformatf("s%0d_d1", e.tag), {ex1, ov1, un1, res1}, e.e1);
                chk($sformatf("s%0d_d2", e.tag), {ex2, ov2, un2, res2}, e.e2);
                if (draining && sb.size() == 0) mon_done = 1'b1;
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL s%0d_missed: due cycle %0d, now %0d", e.tag, e.due, cyc);
            end else begin
                check_zero("idle_zero");
            end
        end
    end

    initial begin
        rst       = 1'b1;
        level_int = '0;
        is_weight = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        send(32'd14562, 1'b1);
        send(32'd4096, 1'b1);
        send(32'd4096, 1'b0);
        send(32'd0, 1'b1);
        send(32'hFFFFFFFF, 1'b1);
        send(32'd1, 1'b0);
        send(32'd8192, 1'b1);
        send(-32'sd16384, 1'b1);
        send(32'h7FFFFFFF, 1'b1);
        send(32'h80000000, 1'b1);
        send(32'd4, 1'b1);
        send(-32'sd4, 1'b1);
        send(32'd1, 1'b1);
        send(32'd2, 1'b1);
        send(32'd0, 1'b0);
        send(32'd5, 1'b0);
        send(-32'sd5, 1'b0);
        send(32'd16777217, 1'b1);
        send_random(200);

        // Mid-stream reset: in-flight samples are dropped and must never appear
        rst = 1'b1;
        sb.delete();
        #1;
        check_zero("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        send(32'd14562, 1'b1);
        send(32'h80000000, 1'b0);
        send_random(150);

        draining = 1'b1;
        for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
        if (!mon_done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            mon_done = 1'b1;
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
